// File: rtl/adc_spi_capture.sv
// rtl/adc_spi_capture.sv - SPI master capturing one 12-bit ADC sample per sample_clk rising edge
// Optional build macro ADC_SIGNED_OUT_EN converts offset-binary samples to two's complement.
module adc_spi_capture #(
  parameter int DATA_W     = 12,
  parameter int FRAME_BITS = 16,
  parameter int SCLK_DIV   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_clk,
  input  logic              miso,
  output logic              cs_n,
  output logic              sclk,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int CW = $clog2(SCLK_DIV + 1);

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, QUIET} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [4:0]            bit_cnt, bit_n;
  logic                  phase, phase_n;
  logic [FRAME_BITS-1:0] shift;
  logic                  sc_q;
  logic                  start;
  logic                  sample_now;
  logic                  last_cyc;
  logic                  frame_done;
  logic [DATA_W-1:0]     captured;

  assign start      = sample_clk & ~sc_q;
  assign last_cyc   = (cnt == CW'(SCLK_DIV - 1));
  assign frame_done = (state == SHIFT) && (state_n == QUIET);

`ifdef ADC_SIGNED_OUT_EN
  assign captured = {~shift[DATA_W-1], shift[DATA_W-2:0]};
`else
  assign captured = shift[DATA_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // phase 0 = sclk low half, phase 1 = sclk high half of the current bit
  always_comb begin
    state_n    = state;
    cnt_n      = cnt + CW'(1);
    bit_n      = bit_cnt;
    phase_n    = phase;
    sample_now = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        bit_n   = '0;
        phase_n = 1'b0;
        if (start) state_n = CS_SETUP;
      end
      CS_SETUP: begin
        if (last_cyc) begin
          cnt_n   = '0;
          state_n = SHIFT;
          phase_n = 1'b0;
          bit_n   = '0;
        end
      end
      SHIFT: begin
        if (last_cyc) begin
          cnt_n = '0;
          if (!phase) begin
            phase_n    = 1'b1;
            sample_now = 1'b1;
          end else if (bit_cnt == 5'(FRAME_BITS - 1)) begin
            state_n = QUIET;
          end else begin
            phase_n = 1'b0;
            bit_n   = bit_cnt + 5'd1;
          end
        end
      end
      QUIET: begin
        if (last_cyc) begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      bit_cnt      <= '0;
      phase        <= 1'b0;
      shift        <= '0;
      sc_q         <= 1'b1;
      cs_n         <= 1'b1;
      sclk         <= 1'b1;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      cnt          <= cnt_n;
      bit_cnt      <= bit_n;
      phase        <= phase_n;
      sc_q         <= sample_clk;
      cs_n         <= (state_n == IDLE) || (state_n == QUIET);
      sclk         <= !((state_n == SHIFT) && !phase_n);
      busy         <= (state_n != IDLE);
      overrun      <= start && (state != IDLE);
      sample_valid <= frame_done;
      if (sample_now) shift <= {shift[FRAME_BITS-2:0], miso};
      if (frame_done) sample_data <= captured;
    end
  end

endmodule

// File: tb/tb_adc_spi_capture.sv
// tb/tb_adc_spi_capture.sv - directed bench for adc_spi_capture with a cycle-level ADC model
module tb_adc_spi_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_clk = 1'b1;
  logic        miso = 1'b0;
  logic        cs_n;
  logic        sclk;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  int          total = 0;
  int          bad = 0;
  logic [15:0] adc_word = 16'h0000;
  int          bit_idx = 0;
  logic        prev_sclk = 1'b1;

  adc_spi_capture dut (
    .clk(clk), .reset(reset), .sample_clk(sample_clk), .miso(miso),
    .cs_n(cs_n), .sclk(sclk), .sample_data(sample_data),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_data(input logic [15:0] w);
    logic [11:0] r;
    r = w[11:0];
`ifdef ADC_SIGNED_OUT_EN
    r[11] = ~r[11];
`endif
    return r;
  endfunction

  // ADC shifts the next bit out on each falling sclk while selected
  task automatic adc_step();
    if (cs_n) begin
      bit_idx = 0;
    end else if (prev_sclk && !sclk) begin
      if (bit_idx < 16) miso = adc_word[15 - bit_idx];
      bit_idx++;
    end
    prev_sclk = sclk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    adc_step();
  endtask

  // Start edge lands in cycle N; cycle N+c is observed c edges later
  task automatic run_frame(input string tag, input logic [15:0] word, input int ovr_at, input int rst_at);
    int          n_valid, valid_at, rises, n_ovr, ovr_seen, glitch;
    logic        cs_1, busy_1, cs_132, cs_133, busy_136, busy_137, last_sclk;
    logic        r_cs, r_sclk, r_busy;
    logic [11:0] vdata, prev_data;
    n_valid = 0; valid_at = -1; rises = 0; n_ovr = 0; ovr_seen = -1; glitch = 0;
    cs_1 = 1'b1; busy_1 = 1'b0; cs_132 = 1'b1; cs_133 = 1'b0; busy_136 = 1'b0; busy_137 = 1'b1;
    r_cs = 1'b0; r_sclk = 1'b0; r_busy = 1'b1; vdata = 12'h000;
    adc_word = word;
    sample_clk = 1'b0;
    repeat (3) tick();
    sample_clk = 1'b1;
    last_sclk = sclk;
    prev_data = sample_data;
    for (int c = 1; c <= 140; c++) begin
      tick();
      if (c == ovr_at - 1) sample_clk = 1'b0;
      if (c == ovr_at) sample_clk = 1'b1;
      reset = (c == rst_at);
      if (!cs_n && !last_sclk && sclk) rises++;
      last_sclk = sclk;
      if (sample_valid) begin n_valid++; valid_at = c; vdata = sample_data; end
      if (overrun) begin n_ovr++; ovr_seen = c; end
      if (rst_at < 0 && !sample_valid && sample_data !== prev_data) glitch++;
      prev_data = sample_data;
      if (c == 1) begin cs_1 = cs_n; busy_1 = busy; end
      if (c == 132) cs_132 = cs_n;
      if (c == 133) cs_133 = cs_n;
      if (c == 136) busy_136 = busy;
      if (c == 137) busy_137 = busy;
      if (c == rst_at + 1) begin r_cs = cs_n; r_sclk = sclk; r_busy = busy; end
    end
    reset = 1'b0;
    chk({tag, ".cs_n_at_1"}, 32'(cs_1), 32'd0);
    chk({tag, ".busy_at_1"}, 32'(busy_1), 32'd1);
    if (rst_at >= 0) begin
      chk({tag, ".rst_cs_n"}, 32'(r_cs), 32'd1);
      chk({tag, ".rst_sclk"}, 32'(r_sclk), 32'd1);
      chk({tag, ".rst_busy"}, 32'(r_busy), 32'd0);
      chk({tag, ".rst_no_valid"}, 32'(n_valid), 32'd0);
      chk({tag, ".rst_data"}, 32'(sample_data), 32'd0);
    end else begin
      chk({tag, ".sclk_rises"}, 32'(rises), 32'd16);
      chk({tag, ".cs_n_at_132"}, 32'(cs_132), 32'd0);
      chk({tag, ".cs_n_at_133"}, 32'(cs_133), 32'd1);
      chk({tag, ".valid_count"}, 32'(n_valid), 32'd1);
      chk({tag, ".valid_at"}, 32'(valid_at), 32'd133);
      chk({tag, ".data"}, 32'(vdata), 32'(exp_data(word)));
      chk({tag, ".busy_at_136"}, 32'(busy_136), 32'd1);
      chk({tag, ".busy_at_137"}, 32'(busy_137), 32'd0);
      chk({tag, ".data_glitch"}, 32'(glitch), 32'd0);
      chk({tag, ".overrun_count"}, 32'(n_ovr), (ovr_at >= 0) ? 32'd1 : 32'd0);
      if (ovr_at >= 0) chk({tag, ".overrun_at"}, 32'(ovr_seen), 32'(ovr_at + 1));
    end
  endtask

  logic [15:0] div_words [3] = '{16'h0000, 16'h0FFF, 16'h0555};

  initial begin
    int quiet_bad, n_valid, n_ovr, frame, vcnt;
    logic prev_cs;
    logic [11:0] got [3];

    // Reset held with sample_clk already high: no frame afterwards
    reset = 1'b1;
    sample_clk = 1'b1;
    repeat (4) tick();
    chk("reset.cs_n", 32'(cs_n), 32'd1);
    chk("reset.sclk", 32'(sclk), 32'd1);
    chk("reset.data", 32'(sample_data), 32'd0);
    chk("reset.valid", 32'(sample_valid), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    quiet_bad = 0;
    repeat (20) begin
      tick();
      if (cs_n !== 1'b1 || busy !== 1'b0) quiet_bad++;
    end
    chk("release_high.no_frame", 32'(quiet_bad), 32'd0);

    run_frame("abc", 16'h0ABC, -1, -1);
    run_frame("mid", 16'h0800, -1, -1);
    run_frame("ovr", 16'h0123, 50, -1);
    run_frame("rst", 16'h0FFF, -1, 70);
    run_frame("after_rst", 16'h0456, -1, -1);

    // Free-running divider: 2269-cycle period, three rising edges
    n_valid = 0; n_ovr = 0; frame = 0; vcnt = 0;
    prev_cs = cs_n;
    for (int t = 0; t < 3 * 2269 + 300; t++) begin
      sample_clk = ((t % 2269) >= 1135);
      tick();
      if (prev_cs && !cs_n && frame < 3) begin adc_word = div_words[frame]; frame++; end
      prev_cs = cs_n;
      if (sample_valid) begin
        if (vcnt < 3) got[vcnt] = sample_data;
        vcnt++;
      end
      if (overrun) n_ovr++;
    end
    n_valid = vcnt;
    chk("div.valid_count", 32'(n_valid), 32'd3);
    chk("div.overrun_count", 32'(n_ovr), 32'd0);
    for (int k = 0; k < 3; k++) chk($sformatf("div.data%0d", k), 32'(got[k]), 32'(exp_data(div_words[k])));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
